// File: rtl/tx_tlp_arbiter_pkg.sv
// Shared constants and types for the TX TLP arbiter and the rx trigger.
package tx_tlp_arbiter_pkg;

  localparam int QW_W = 5;

  localparam logic [1:0] ENG_SEL_NONE = 2'd0;
  localparam logic [1:0] ENG_SEL_DATA = 2'd1;
  localparam logic [1:0] ENG_SEL_HP   = 2'd2;
  localparam logic [1:0] ENG_SEL_CPL  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  typedef struct packed {
    logic [1:0]      sel;
    logic [QW_W-1:0] qwords;
    logic            last;
  } grant_t;

  // Ack vector ordered {cpl, hp, data} for the given engine selection.
  function automatic logic [2:0] ack_vec(input logic [1:0] sel);
    logic [2:0] v;
    v = 3'b000;
    case (sel)
      ENG_SEL_DATA: v = 3'b001;
      ENG_SEL_HP:   v = 3'b010;
      ENG_SEL_CPL:  v = 3'b100;
      default:      v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tx_tlp_arbiter_sync_2ff.sv
// Single-bit two-flop synchronizer, clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tx_tlp_arbiter.sv
// Arbitrates the TX TLP engine between data, huge-page and completion requesters
// (cpl > hp > data, with a bounded cpl burst while rx work waits) plus a job watchdog.
module tx_tlp_arbiter
  import tx_tlp_arbiter_pkg::*;
#(
  parameter int MAX_CPL_BURST = 4,
  parameter int WDOG_CYCLES   = 1024,
  parameter int WDOG_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_req,
  output logic            data_ack,
  input  logic            hp_req,
  input  logic            hp_last,
  output logic            hp_ack,
  input  logic [QW_W-1:0] qwords_to_send,
  input  logic            cpl_req,
  output logic            cpl_ack,
  output logic [1:0]      eng_sel,
  output logic [QW_W-1:0] eng_qwords,
  output logic            eng_last,
  output logic            eng_start,
  input  logic            eng_done,
  output logic            busy,
  output logic            wdog_err
);

  localparam int                BW        = $clog2(MAX_CPL_BURST + 1);
  localparam logic [BW-1:0]     BURST_MAX = BW'(MAX_CPL_BURST);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic              dreq_s, hreq_s;
  logic [1:0]        state;
  logic [BW-1:0]     burst_cnt;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              rx_pend, cpl_ok, win_req;
  grant_t            nxt;

  sync_2ff u_dreq_sync (.clk(clk), .reset(reset), .d(data_req), .q(dreq_s));
  sync_2ff u_hreq_sync (.clk(clk), .reset(reset), .d(hp_req),   .q(hreq_s));

  // cpl yields one arbitration once it has used up its burst against waiting rx work
  always_comb begin
    rx_pend = dreq_s | hreq_s;
    cpl_ok  = cpl_req & ~((burst_cnt == BURST_MAX) & rx_pend);
    nxt     = '0;
    if (cpl_ok) begin
      nxt.sel = ENG_SEL_CPL;
    end else if (hreq_s) begin
      nxt.sel    = ENG_SEL_HP;
      nxt.qwords = qwords_to_send;
      nxt.last   = hp_last;
    end else if (dreq_s) begin
      nxt.sel    = ENG_SEL_DATA;
      nxt.qwords = qwords_to_send;
    end
  end

  always_comb begin
    win_req = 1'b0;
    case (eng_sel)
      ENG_SEL_DATA: win_req = dreq_s;
      ENG_SEL_HP:   win_req = hreq_s;
      ENG_SEL_CPL:  win_req = cpl_req;
      default:      win_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      eng_sel    <= ENG_SEL_NONE;
      eng_qwords <= '0;
      eng_last   <= 1'b0;
      data_ack   <= 1'b0;
      hp_ack     <= 1'b0;
      cpl_ack    <= 1'b0;
      burst_cnt  <= '0;
      wdog_cnt   <= '0;
      wdog_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (nxt.sel != ENG_SEL_NONE) begin
            eng_sel    <= nxt.sel;
            eng_qwords <= nxt.qwords;
            eng_last   <= nxt.last;
            state      <= ST_START;
            if ((nxt.sel == ENG_SEL_CPL) && rx_pend) begin
              if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
            end else begin
              burst_cnt <= '0;
            end
          end
        end
        ST_START: begin
          wdog_cnt <= '0;
          state    <= ST_BUSY;
        end
        ST_BUSY: begin
          wdog_cnt <= wdog_cnt + 1'b1;
          if (eng_done) begin
            {cpl_ack, hp_ack, data_ack} <= ack_vec(eng_sel);
            state <= ST_ACK;
          end else if (wdog_cnt == WDOG_LAST) begin
            // never leave a requester hung: flag it and complete the handshake anyway
            wdog_err <= 1'b1;
            {cpl_ack, hp_ack, data_ack} <= ack_vec(eng_sel);
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!win_req) begin
            {cpl_ack, hp_ack, data_ack} <= 3'b000;
            eng_sel <= ENG_SEL_NONE;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign eng_start = (state == ST_START);

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Randomized scoreboard bench for tx_tlp_arbiter with a grant-rule reference model.
module tb_tx_tlp_arbiter;

  localparam int MAXB = 4;
  localparam int WDOG = 1024;

  typedef struct packed {
    logic [1:0] sel;
    logic [4:0] qw;
    logic       last;
  } exp_t;

  logic       clk = 1'b0, reset = 1'b1;
  logic       data_req = 1'b0, hp_req = 1'b0, hp_last = 1'b0, cpl_req = 1'b0, eng_done = 1'b0;
  logic [4:0] qwords_to_send = 5'd0;
  logic       data_ack, hp_ack, cpl_ack, eng_last, eng_start, busy, wdog_err;
  logic [1:0] eng_sel;
  logic [4:0] eng_qwords;

  tx_tlp_arbiter #(.MAX_CPL_BURST(MAXB), .WDOG_CYCLES(WDOG), .WDOG_W(16)) dut (
    .clk(clk), .reset(reset),
    .data_req(data_req), .data_ack(data_ack),
    .hp_req(hp_req), .hp_last(hp_last), .hp_ack(hp_ack),
    .qwords_to_send(qwords_to_send),
    .cpl_req(cpl_req), .cpl_ack(cpl_ack),
    .eng_sel(eng_sel), .eng_qwords(eng_qwords), .eng_last(eng_last),
    .eng_start(eng_start), .eng_done(eng_done),
    .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  logic cpl_seen = 1'b0, rst_seen = 1'b1;

  // what the DUT sampled at the most recent rising edge
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    cpl_seen <= cpl_req;
    rst_seen <= reset;
  end

  // model / scoreboard state
  exp_t       exp_q[$];
  bit         rx_pending = 0;
  int         rx_raise = 0, cpl_raise = 0;
  logic [1:0] rx_kind = 2'd0;
  int         burst_m = 0;
  int         grant_cnt[4] = '{0, 0, 0, 0};
  int         last_grant = 0, start_cyc = 0, done_cyc = 0;
  bit         eng_hang = 0, cpl_run = 0, cpl_zero = 0, cpl_done = 1;
  int         eng_dmin = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // engine: answer each start with a done pulse a few cycles later
  initial forever begin
    int d;
    @(negedge clk);
    if (eng_start && !eng_hang) begin
      d = $urandom_range(eng_dmin + 5, eng_dmin);
      repeat (d) @(negedge clk);
      eng_done = 1'b1;
      done_cyc = cyc;
      @(negedge clk);
      eng_done = 1'b0;
    end
  end

  // monitor: every grant is checked against the arbitration rules, every ack against its cause
  initial begin
    logic [2:0] prev_ack;
    logic       prev_start;
    prev_ack   = 3'b000;
    prev_start = 1'b0;
    forever begin
      bit         comp;
      logic [1:0] expsel;
      logic [2:0] ack;
      exp_t       e;
      @(negedge clk);
      if (rst_seen) begin
        burst_m    = 0;
        prev_ack   = 3'b000;
        prev_start = 1'b0;
      end else begin
        if (eng_start) begin
          chk("start_pulse_width", prev_start, 0);
          chk("busy_at_start", busy, 1);
          comp = rx_pending && (cyc >= rx_raise + 3);
          if (cpl_seen && !(burst_m == MAXB && comp)) expsel = 2'd3;
          else if (comp) expsel = rx_kind;
          else expsel = 2'd0;
          chk("grant_sel", eng_sel, expsel);
          grant_cnt[eng_sel]++;
          last_grant = cyc;
          start_cyc  = cyc;
          if (eng_sel == 2'd3) begin
            burst_m = comp ? ((burst_m < MAXB) ? burst_m + 1 : MAXB) : 0;
          end else if (eng_sel != 2'd0) begin
            burst_m    = 0;
            rx_pending = 0;
            chk("rx_queue_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("rx_grant_src", eng_sel, e.sel);
              chk("eng_qwords", eng_qwords, e.qw);
              chk("eng_last", eng_last, e.last);
            end
          end
        end
        ack = {cpl_ack, hp_ack, data_ack};
        for (int s = 0; s < 3; s++) begin
          if (ack[s] && !prev_ack[s]) begin
            chk("ack_src", eng_sel, s + 1);
            if (done_cyc > start_cyc) begin
              chk("ack_latency", cyc - done_cyc, 1);
            end else begin
              chk("wdog_flag", wdog_err, 1);
              chk("wdog_latency", cyc - start_cyc, WDOG + 1);
            end
          end
          if (!ack[s] && prev_ack[s]) begin
            chk("release_sel", eng_sel, 0);
            chk("release_busy", busy, 0);
          end
        end
        prev_ack   = ack;
        prev_start = eng_start;
      end
    end
  end

  task automatic cpl_job(input int pre, input int hold);
    repeat (pre) @(negedge clk);
    cpl_req   = 1'b1;
    cpl_raise = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cpl_ack) break;
    end
    chk("cpl_ack_rise", cpl_ack, 1);
    repeat (hold) @(negedge clk);
    cpl_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!cpl_ack) break;
    end
    chk("cpl_ack_fall", cpl_ack, 0);
  endtask

  task automatic cpl_loop();
    while (cpl_run) begin
      if (cpl_zero) cpl_job(0, 0);
      else cpl_job($urandom_range(6, 0), $urandom_range(3, 0));
    end
    cpl_done = 1;
  endtask

  task automatic rx_job(input bit hp, input logic [4:0] q, input bit last, input int hold);
    exp_t e;
    qwords_to_send = q;
    hp_last        = hp ? last : 1'b0;
    @(negedge clk);
    e.sel  = hp ? 2'd2 : 2'd1;
    e.qw   = q;
    e.last = hp ? last : 1'b0;
    exp_q.push_back(e);
    rx_kind    = e.sel;
    rx_raise   = cyc;
    rx_pending = 1;
    if (hp) hp_req = 1'b1; else data_req = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hp ? hp_ack : data_ack) break;
    end
    chk("rx_ack_rise", hp ? hp_ack : data_ack, 1);
    repeat (hold) @(negedge clk);
    hp_req   = 1'b0;
    data_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(hp ? hp_ack : data_ack)) break;
    end
    chk("rx_ack_fall", hp ? hp_ack : data_ack, 0);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cpl_done && !busy) break;
    end
    chk("quiesce_busy", busy, 0);
  endtask

  initial begin
    int         g, c0, d0;
    bit         hp, last;
    logic [4:0] q;

    repeat (3) @(negedge clk);
    chk("reset_eng_sel", eng_sel, 0);
    chk("reset_busy", busy, 0);
    chk("reset_start", eng_start, 0);
    chk("reset_acks", {cpl_ack, hp_ack, data_ack}, 0);
    chk("reset_wdog", wdog_err, 0);
    chk("reset_qwords", eng_qwords, 0);
    chk("reset_last", eng_last, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single jobs on an idle engine
    cpl_job(0, 2);
    chk("cpl_latency", last_grant - cpl_raise, 1);
    chk("cpl_done_busy", busy, 0);
    g = grant_cnt[1];
    rx_job(0, 5'd16, 0, 4);
    chk("data_latency", last_grant - rx_raise, 3);
    chk("data_grant_count", grant_cnt[1] - g, 1);
    rx_job(1, 5'd5, 1, 1);
    chk("hp_latency", last_grant - rx_raise, 3);
    rx_job(1, 5'd0, 0, 2);

    // a done pulse with no job in flight changes nothing
    @(negedge clk) eng_done = 1'b1;
    @(negedge clk) eng_done = 1'b0;
    chk("stray_done_busy", busy, 0);
    chk("stray_done_acks", {cpl_ack, hp_ack, data_ack}, 0);
    @(negedge clk);
    chk("stray_done_acks2", {cpl_ack, hp_ack, data_ack}, 0);

    // back-to-back cpl with a data job waiting: burst limit then cpl resumes
    eng_dmin = 3; cpl_zero = 1; cpl_run = 1; cpl_done = 0;
    fork cpl_loop(); join_none
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eng_start) break;
    end
    q = 5'($urandom_range(16, 1));
    fork rx_job(0, q, 0, 0); join_none
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_req) break;
    end
    c0 = grant_cnt[3];
    d0 = grant_cnt[1];
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (grant_cnt[1] != d0) break;
    end
    chk("burst_len", grant_cnt[3] - c0, MAXB);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (grant_cnt[3] > c0 + MAXB) break;
    end
    chk("cpl_resumes", grant_cnt[3] - c0, MAXB + 1);
    cpl_run = 0;
    wait_quiet();
    eng_dmin = 1;

    // random traffic from both sides
    cpl_zero = 0; cpl_run = 1; cpl_done = 0;
    fork cpl_loop(); join_none
    for (int n = 0; n < 40; n++) begin
      hp   = bit'($urandom_range(1, 0));
      last = bit'($urandom_range(1, 0));
      q    = (hp && !last) ? 5'($urandom_range(16, 0)) : 5'($urandom_range(16, 1));
      rx_job(hp, q, last, $urandom_range(3, 0));
      repeat ($urandom_range(4, 0)) @(negedge clk);
    end
    cpl_run = 0;
    wait_quiet();

    // engine never finishes
    eng_hang = 1;
    cpl_job(0, 0);
    chk("wdog_sticky", wdog_err, 1);
    chk("wdog_busy", busy, 0);
    eng_hang = 0;

    // reset in the middle of a job
    eng_hang = 1;
    @(negedge clk) cpl_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eng_start) break;
    end
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset   = 1'b1;
    cpl_req = 1'b0;
    @(negedge clk);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_sel", eng_sel, 0);
    chk("mid_reset_start", eng_start, 0);
    chk("mid_reset_acks", {cpl_ack, hp_ack, data_ack}, 0);
    chk("mid_reset_wdog", wdog_err, 0);
    chk("mid_reset_qwords", eng_qwords, 0);
    reset    = 1'b0;
    eng_hang = 0;
    @(negedge clk);
    cpl_job(0, 1);
    chk("post_reset_latency", last_grant - cpl_raise, 1);
    chk("post_reset_wdog", wdog_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_tlp_arbiter.md
Name: tx_tlp_arbiter

Overview:
- Arbitrates the single PCIe TX TLP engine between three requesters:
  - rx data TLP trigger (data_req)
  - huge-page close / last-TLP request (hp_req)
  - PIO read completion request (cpl_req)
- Sits in the TX engine clock domain. data_req and hp_req originate in the rx trigger domain and are synchronized here; cpl_req is native.
- All three requesters use a 4-phase req/ack handshake. The engine side uses a start-pulse/done-pulse handshake.

Parameters:
- MAX_CPL_BURST, 4: max consecutive cpl grants while data_req or hp_req is pending.
- WDOG_CYCLES, 1024: cycles allowed between eng_start and eng_done before the watchdog fires.
- WDOG_W, 16: watchdog counter width; WDOG_CYCLES < 2^WDOG_W.

Ports:
- clk  in  1  TX-domain clock
- reset  in  1  synchronous, active-high reset
- data_req  in  1  data TLP request, level, async domain
- data_ack  out  1  data TLP ack, registered
- hp_req  in  1  change-huge-page request, level, async domain
- hp_last  in  1  with hp_req: send last partial TLP before page change; stable while hp_req high
- hp_ack  out  1  change-huge-page ack, registered
- qwords_to_send  in  5  payload qwords (1..16); stable ≥1 cycle before and throughout data_req/hp_req
- cpl_req  in  1  completion request, level, this domain
- cpl_ack  out  1  completion ack
- eng_sel  out  2  granted source: 0 none, 1 data, 2 hp, 3 cpl
- eng_qwords  out  5  latched qwords for the granted data/hp job
- eng_last  out  1  latched hp_last for an hp grant
- eng_start  out  1  one-cycle start pulse to TX engine
- eng_done  in  1  one-cycle completion pulse from TX engine
- busy  out  1  FSM not in IDLE
- wdog_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset: all outputs 0, FSM IDLE, sync flops 0, burst and watchdog counters 0.
- Synchronization: data_req and hp_req each pass through 2 flops (dreq_s, hreq_s). All decisions use the synchronized versions; cpl_req is used directly.
- FSM states: IDLE, START, BUSY, ACK.
- IDLE: if any request is visible, pick a winner, latch eng_sel, eng_qwords and eng_last, then go to START.
  - Priority: cpl > hp > data.
  - Exception: when burst_cnt == MAX_CPL_BURST and (hreq_s | dreq_s), cpl is skipped for this arbitration.
- START: eng_start=1 for exactly this cycle; go to BUSY. Watchdog counter cleared.
- BUSY: watchdog increments each cycle.
  - On eng_done: assert the winner's ack, go to ACK.
  - If the count reaches WDOG_CYCLES first: set wdog_err, assert the winner's ack, go to ACK. A job is never hung.
- ACK: hold the ack until the winner's (synchronized) request is low. Then drop the ack, set eng_sel=0, go to IDLE.
- The ack-to-IDLE sequence guarantees the same request is never re-granted on a stale level.
- Burst counter:
  - Increments on a cpl grant while dreq_s | hreq_s is high.
  - Resets to 0 on any data/hp grant, or on a cpl grant with no competing request.
  - Saturates at MAX_CPL_BURST.
- Latency:
  - cpl_req rising at edge N → eng_start high at cycle N+1 (idle engine).
  - data_req/hp_req rising at edge N → eng_start at N+3.
- eng_done outside BUSY is ignored.
- data_req and hp_req are mutually exclusive by construction of the rx trigger. If both are seen, hp wins and data waits; no error.
- Simultaneous release and new request in ACK: the new request is not considered until IDLE (one idle cycle minimum between jobs).
- Reset mid-job: immediate return to IDLE with all acks 0. Requesters observe ack low and follow the 4-phase protocol.
- eng_qwords passes through unmodified, with no range check. A value of 0 is legal for an hp job only when hp_last=0.

Decomposition:
- Shared package/include holds:
  - ENG_SEL_NONE/DATA/HP/CPL constants
  - FSM state encodings
  - qwords width constant (5), shared with the rx trigger
- One sub-module: sync_2ff (single-bit, reset-to-0 two-flop synchronizer), instantiated twice.

Test Plan:
- cpl_req alone at cycle 10 → eng_sel=3, eng_start at 11; eng_done at 20 → cpl_ack at 21; cpl_req drop at 23 → cpl_ack 0 at 24, busy 0.
- data_req with qwords_to_send=16 at cycle 10 → eng_start at 13, eng_qwords=16, eng_sel=1; full 4-phase completes; no second grant while data_req is still high.
- hp_req with hp_last=1 and qwords=5 → eng_sel=2, eng_last=1, eng_qwords=5. With hp_last=0 and qwords=0 → eng_last=0.
- cpl_req held continuously with data_req pending → exactly 4 cpl grants, then 1 data grant, then cpl resumes, with burst_cnt reset.
- Engine never pulses eng_done → wdog_err=1 after 1024 BUSY cycles, ack still issued, FSM returns to IDLE.
- Reset asserted in BUSY → next cycle all outputs 0, FSM IDLE. A subsequent cpl_req is granted normally.
